// File: rtl/game_turn_fsm.sv
// Turn-based board game controller: cursor movement, legality handshake, placement, turn rotation.
// Optional pass-limit feature enabled by defining GAME_TURN_PASS_LIMIT_EN.
module game_turn_fsm #(
    parameter int BOARD_N  = 8,
    parameter int PLAYERS  = 2,
    parameter int RATE_DIV = 833333,
    localparam int CW = $clog2(BOARD_N),
    localparam int PW = (PLAYERS > 2) ? $clog2(PLAYERS) : 1
) (
    input  logic          clk,
    input  logic          restart,
    input  logic          go,
    input  logic          move_up,
    input  logic          move_down,
    input  logic          move_left,
    input  logic          move_right,
    input  logic          place,
    input  logic          jump,
    input  logic          detect_done,
    input  logic          confirm,
    input  logic          win,
    output logic [PW-1:0] turn_side,
    output logic [CW-1:0] cursor_x,
    output logic [CW-1:0] cursor_y,
    output logic          draw_cell,
    output logic          plot_empty,
    output logic          place_disk,
    output logic          detect,
    output logic          game_over,
    output logic [3:0]    state
);
    localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_DRAW   = 4'd1,
        ST_SELECT = 4'd2,
        ST_ERASE  = 4'd3,
        ST_REDRAW = 4'd4,
        ST_DETECT = 4'd5,
        ST_PLACE  = 4'd6,
        ST_END    = 4'd7
    } state_e;

    typedef enum logic [1:0] {DIR_UP, DIR_DN, DIR_LF, DIR_RT} dir_e;

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [PW-1:0] turn_q, turn_d, turn_nxt;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [RW-1:0] rate_q, rate_d;
    logic          any_move;
`ifdef GAME_TURN_PASS_LIMIT_EN
    localparam int PCW = $clog2(PLAYERS + 1);
    logic [PCW-1:0] pass_q, pass_d;
`endif

    assign any_move = move_up | move_down | move_left | move_right;
    assign turn_nxt = (turn_q == PW'(PLAYERS - 1)) ? '0 : turn_q + PW'(1);

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= ST_START;
            dir_q   <= DIR_UP;
            turn_q  <= '0;
            cx_q    <= CW'(BOARD_N / 2 - 1);
            cy_q    <= CW'(BOARD_N / 2 - 1);
            rate_q  <= '0;
`ifdef GAME_TURN_PASS_LIMIT_EN
            pass_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rate_q  <= rate_d;
`ifdef GAME_TURN_PASS_LIMIT_EN
            pass_q  <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        turn_d     = turn_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        rate_d     = (rate_q != '0) ? rate_q - RW'(1) : '0;
`ifdef GAME_TURN_PASS_LIMIT_EN
        pass_d     = pass_q;
`endif
        draw_cell  = 1'b0;
        plot_empty = 1'b0;
        place_disk = 1'b0;
        detect     = 1'b0;
        game_over  = 1'b0;
        case (state_q)
            ST_START:  if (go) state_d = ST_DRAW;
            ST_DRAW:   state_d = ST_SELECT;
            ST_SELECT: begin
                draw_cell = 1'b1;
                if (jump) begin
`ifdef GAME_TURN_PASS_LIMIT_EN
                    // Every player passing in a row ends the game; turn is left as is.
                    if (int'(pass_q) + 1 >= PLAYERS) begin
                        pass_d  = PCW'(PLAYERS);
                        state_d = ST_END;
                    end else begin
                        pass_d = pass_q + PCW'(1);
                        turn_d = turn_nxt;
                    end
`else
                    turn_d = turn_nxt;
`endif
                end else if (place) begin
                    state_d = ST_DETECT;
                end else if (any_move && rate_q == '0) begin
                    state_d = ST_ERASE;
                    rate_d  = RW'(RATE_DIV - 1);
                    if (move_up)        dir_d = DIR_UP;
                    else if (move_down) dir_d = DIR_DN;
                    else if (move_left) dir_d = DIR_LF;
                    else                dir_d = DIR_RT;
                end
            end
            ST_ERASE: begin
                plot_empty = 1'b1;
                state_d    = ST_REDRAW;
                // Old cell is erased this cycle; cursor moves (saturating) on exit.
                case (dir_q)
                    DIR_UP: if (cy_q != '0) cy_d = cy_q - CW'(1);
                    DIR_DN: if (cy_q != CW'(BOARD_N - 1)) cy_d = cy_q + CW'(1);
                    DIR_LF: if (cx_q != '0) cx_d = cx_q - CW'(1);
                    default: if (cx_q != CW'(BOARD_N - 1)) cx_d = cx_q + CW'(1);
                endcase
            end
            ST_REDRAW: begin
                draw_cell = 1'b1;
                state_d   = ST_SELECT;
            end
            ST_DETECT: begin
                detect = 1'b1;
                if (detect_done) state_d = confirm ? ST_PLACE : ST_SELECT;
            end
            ST_PLACE: begin
                place_disk = 1'b1;
`ifdef GAME_TURN_PASS_LIMIT_EN
                pass_d = '0;
`endif
                if (win) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_SELECT;
                    turn_d  = turn_nxt;
                end
            end
            ST_END: begin
                game_over = 1'b1;
                if (go) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    assign turn_side = turn_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;
    assign state     = state_q;
endmodule

// File: tb/tb_game_turn_fsm.sv
// Vector-table bench for game_turn_fsm (BOARD_N=8, PLAYERS=3, RATE_DIV=4) plus multi-cycle corner sequences.
module tb_game_turn_fsm;
    localparam logic [10:0] I_RST = 11'h400, I_G = 11'h200, I_U = 11'h100, I_D = 11'h080,
                            I_L = 11'h040, I_R = 11'h020, I_P = 11'h010, I_J = 11'h008,
                            I_DD = 11'h004, I_CF = 11'h002, I_W = 11'h001;
    localparam logic [4:0] S_DC = 5'b10000, S_PE = 5'b01000, S_PD = 5'b00100,
                           S_DT = 5'b00010, S_GO = 5'b00001;
    localparam logic [3:0] START = 4'd0, DRAW = 4'd1, SEL = 4'd2, ERASE = 4'd3,
                           REDRAW = 4'd4, DET = 4'd5, PLACE = 4'd6, FIN = 4'd7;

    logic clk = 1'b0;
    logic restart, go, move_up, move_down, move_left, move_right;
    logic place, jump, detect_done, confirm, win;
    logic [1:0] turn_side;
    logic [2:0] cursor_x, cursor_y;
    logic draw_cell, plot_empty, place_disk, detect, game_over;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [10:0] in;
        logic [3:0]  st;
        logic [1:0]  tn;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [4:0]  sb;
    } vec_t;
    vec_t vq[$];

    game_turn_fsm #(.BOARD_N(8), .PLAYERS(3), .RATE_DIV(4)) dut (
        .clk(clk), .restart(restart), .go(go),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .place(place), .jump(jump), .detect_done(detect_done), .confirm(confirm), .win(win),
        .turn_side(turn_side), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .draw_cell(draw_cell), .plot_empty(plot_empty), .place_disk(place_disk),
        .detect(detect), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    task automatic addv(input logic [10:0] in, input logic [3:0] st, input logic [1:0] tn,
                        input logic [2:0] x, input logic [2:0] y, input logic [4:0] sb);
        vec_t v;
        v.in = in; v.st = st; v.tn = tn; v.x = x; v.y = y; v.sb = sb;
        vq.push_back(v);
    endtask

    task automatic setin(input logic [10:0] v);
        {restart, go, move_up, move_down, move_left, move_right,
         place, jump, detect_done, confirm, win} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {draw_cell, plot_empty, place_disk, detect, game_over};
    endfunction

    initial begin
        int ne, nr;
        setin(11'h0);
        // reset and start
        addv(I_RST,           START, 0, 3, 3, 5'b0);
        addv(0,               START, 0, 3, 3, 5'b0);
        addv(I_P | I_J | I_U, START, 0, 3, 3, 5'b0);
        addv(I_G,             DRAW,  0, 3, 3, 5'b0);
        addv(I_P,             SEL,   0, 3, 3, S_DC);
        // rejected placement: detect high six cycles
        addv(I_P,             DET,   0, 3, 3, S_DT);
        for (int k = 0; k < 5; k++) addv(I_J | I_U, DET, 0, 3, 3, S_DT);
        addv(I_DD | I_W,      SEL,   0, 3, 3, S_DC);
        // accepted placement, no win
        addv(I_P,             DET,   0, 3, 3, S_DT);
        addv(I_DD | I_CF,     PLACE, 0, 3, 3, S_PD);
        addv(I_G,             SEL,   1, 3, 3, S_DC);
        // moves and rate limiting
        addv(I_U | I_L,       ERASE, 1, 3, 3, S_PE);
        addv(0,               REDRAW,1, 3, 2, S_DC);
        addv(0,               SEL,   1, 3, 2, S_DC);
        addv(I_R,             SEL,   1, 3, 2, S_DC);
        addv(I_R,             ERASE, 1, 3, 2, S_PE);
        addv(I_R,             REDRAW,1, 4, 2, S_DC);
        addv(0,               SEL,   1, 4, 2, S_DC);
        addv(0,               SEL,   1, 4, 2, S_DC);
        addv(I_D | I_R,       ERASE, 1, 4, 2, S_PE);
        addv(0,               REDRAW,1, 4, 3, S_DC);
        addv(0,               SEL,   1, 4, 3, S_DC);
        // place beats move; win ends the game
        addv(I_P | I_U,       DET,   1, 4, 3, S_DT);
        addv(I_DD | I_CF,     PLACE, 1, 4, 3, S_PD);
        addv(I_W,             FIN,   1, 4, 3, S_GO);
        addv(I_P | I_J,       FIN,   1, 4, 3, S_GO);
        addv(I_G,             START, 1, 4, 3, 5'b0);
        addv(I_G,             DRAW,  1, 4, 3, 5'b0);
        addv(0,               SEL,   1, 4, 3, S_DC);
        // restart mid-DETECT with a confirm pending
        addv(I_P,             DET,   1, 4, 3, S_DT);
        addv(I_RST | I_DD | I_CF, START, 0, 3, 3, 5'b0);
        addv(0,               START, 0, 3, 3, 5'b0);

        foreach (vq[i]) begin
            setin(vq[i].in);
            step();
            chk($sformatf("vec%0d", i), {16'h0, state, turn_side, cursor_x, cursor_y, strobes()},
                {16'h0, vq[i].st, vq[i].tn, vq[i].x, vq[i].y, vq[i].sb});
        end

        // move_right held 12 cycles: three erase/redraw pairs
        setin(I_G); step(); setin(0); step();
        chk("sel_entry", state, SEL);
        ne = 0; nr = 0;
        setin(I_R);
        for (int k = 0; k < 12; k++) begin
            step();
            if (state == ERASE) ne++;
            if (state == REDRAW) nr++;
        end
        setin(0); step();
        chk("rate_erase_cnt", ne, 3);
        chk("rate_redraw_cnt", nr, 3);
        chk("rate_cursor_x", cursor_x, 6);
        chk("rate_state", state, SEL);

        // drive to the (0,0) corner, then a saturated diagonal pulse
        setin(I_U); repeat (16) step();
        setin(I_L); repeat (32) step();
        setin(0); repeat (4) step();
        chk("corner_xy", {cursor_x, cursor_y}, 6'd0);
        setin(I_U | I_L); step();
        chk("sat_erase", {state, strobes()}, {ERASE, S_PE});
        setin(0); step();
        chk("sat_redraw", {state, cursor_x, cursor_y}, {REDRAW, 6'd0});
        step();
        chk("sat_back", state, SEL);

        // consecutive passes
        setin(I_RST); step(); setin(I_G); step(); setin(0); step();
        setin(I_J); step();
        chk("pass1", {state, turn_side}, {SEL, 2'd1});
        step();
        chk("pass2", {state, turn_side}, {SEL, 2'd2});
        step();
`ifdef GAME_TURN_PASS_LIMIT_EN
        chk("pass3", {state, game_over}, {FIN, 1'b1});
        setin(0); step();
        chk("pass_hold", {state, game_over}, {FIN, 1'b1});
`else
        chk("pass3", {state, turn_side, game_over}, {SEL, 2'd0, 1'b0});
        setin(0); step();
        chk("pass_hold", {state, turn_side}, {SEL, 2'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
